// File: rtl/sdram_arb_pkg.sv
// Shared types for the multi-channel SDRAM burst arbiter: FSM state encoding
// and channel-index width helper.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_BURST = 3'd2,
        RD_REQ   = 3'd3,
        RD_BURST = 3'd4
    } arb_state_e;

    function automatic int CH_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// returned as a one-hot grant plus its index.
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]           req_i,
    input  logic [CH_IDX_W(NUM_CH)-1:0] ptr_i,
    output logic [NUM_CH-1:0]           gnt_o,
    output logic [CH_IDX_W(NUM_CH)-1:0] idx_o
);
    localparam int IW = CH_IDX_W(NUM_CH);

    logic          found;
    logic [IW-1:0] c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = IW'((int'(ptr_i) + i) % NUM_CH);
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = c;
            end
        end
    end

endmodule

// File: rtl/sdram_mc_burst_arb.sv
// Schedules per-channel write/read bursts onto one SDRAM request port and owns the
// circular region pointers. Define SDRAM_ARB_WR_PRIO_EN for global write priority.
module sdram_mc_burst_arb
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 24,
    parameter int LVL_W  = 10,
    parameter int BL_W   = 10
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        init_end,
    input  logic [NUM_CH*LVL_W-1:0]     ch_wr_level,
    input  logic [NUM_CH*LVL_W-1:0]     ch_rd_space,
    input  logic [NUM_CH-1:0]           ch_rd_en,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_wr_b_addr,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_wr_e_addr,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_rd_b_addr,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_rd_e_addr,
    input  logic [NUM_CH-1:0]           ch_addr_rst,
    input  logic [BL_W-1:0]             wr_burst_len,
    input  logic [BL_W-1:0]             rd_burst_len,
    output logic                        sdram_wr_req,
    input  logic                        sdram_wr_ack,
    output logic [ADDR_W-1:0]           sdram_wr_addr,
    output logic [BL_W-1:0]             sdram_wr_burst_len,
    output logic                        sdram_rd_req,
    input  logic                        sdram_rd_ack,
    output logic [ADDR_W-1:0]           sdram_rd_addr,
    output logic [BL_W-1:0]             sdram_rd_burst_len,
    output logic [CH_IDX_W(NUM_CH)-1:0] wr_grant_ch,
    output logic [CH_IDX_W(NUM_CH)-1:0] rd_grant_ch,
    output logic                        wr_grant_vld,
    output logic                        rd_grant_vld
);
    localparam int IW = CH_IDX_W(NUM_CH);

    arb_state_e      state_q;
    logic [IW-1:0]   rr_q, wr_ch_q, rd_ch_q;
    logic            wr_req_q, rd_req_q, wr_vld_q, rd_vld_q, sup_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [BL_W-1:0] wr_len_q, rd_len_q;
    logic [ADDR_W-1:0] wr_ptr_q [NUM_CH];
    logic [ADDR_W-1:0] rd_ptr_q [NUM_CH];

    logic [ADDR_W-1:0] wr_b [NUM_CH];
    logic [ADDR_W-1:0] wr_e [NUM_CH];
    logic [ADDR_W-1:0] rd_b [NUM_CH];
    logic [ADDR_W-1:0] rd_e [NUM_CH];
    logic [NUM_CH-1:0] wr_elig, rd_elig;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_b[g] = ch_wr_b_addr[g*ADDR_W +: ADDR_W];
        assign wr_e[g] = ch_wr_e_addr[g*ADDR_W +: ADDR_W];
        assign rd_b[g] = ch_rd_b_addr[g*ADDR_W +: ADDR_W];
        assign rd_e[g] = ch_rd_e_addr[g*ADDR_W +: ADDR_W];
        assign wr_elig[g] = (wr_burst_len != '0) &&
                            (32'(ch_wr_level[g*LVL_W +: LVL_W]) >= 32'(wr_burst_len));
        assign rd_elig[g] = ch_rd_en[g] && (rd_burst_len != '0) &&
                            (32'(ch_rd_space[g*LVL_W +: LVL_W]) >= 32'(rd_burst_len));
    end

    logic          pick_any, grant_wr;
    logic [IW-1:0] pick_idx, rr_next;

`ifdef SDRAM_ARB_WR_PRIO_EN
    logic [NUM_CH-1:0] w_gnt, r_gnt;
    logic [IW-1:0]     w_idx, r_idx;

    sdram_rr_pick #(.NUM_CH(NUM_CH)) u_pick_wr (.req_i(wr_elig), .ptr_i(rr_q), .gnt_o(w_gnt), .idx_o(w_idx));
    sdram_rr_pick #(.NUM_CH(NUM_CH)) u_pick_rd (.req_i(rd_elig), .ptr_i(rr_q), .gnt_o(r_gnt), .idx_o(r_idx));

    assign grant_wr = |w_gnt;
    assign pick_any = grant_wr | (|r_gnt);
    assign pick_idx = grant_wr ? w_idx : r_idx;
`else
    logic [NUM_CH-1:0] any_gnt;

    sdram_rr_pick #(.NUM_CH(NUM_CH)) u_pick (.req_i(wr_elig | rd_elig), .ptr_i(rr_q), .gnt_o(any_gnt), .idx_o(pick_idx));

    // Within the picked channel a pending write outranks its read.
    assign grant_wr = |(any_gnt & wr_elig);
    assign pick_any = |any_gnt;
`endif

    assign rr_next = (pick_idx == IW'(NUM_CH - 1)) ? '0 : pick_idx + IW'(1);

    logic          wr_dir;
    logic [IW-1:0] cur_ch;
    assign wr_dir = (state_q == WR_REQ) || (state_q == WR_BURST);
    assign cur_ch = wr_dir ? wr_ch_q : rd_ch_q;

    // Advance by one burst; fall back to base when the following burst would overrun the region end.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p, input logic [BL_W-1:0] l,
                                                   input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] e);
        logic [ADDR_W+1:0] n, lim;
        n   = (ADDR_W+2)'(p) + (ADDR_W+2)'(l);
        lim = (ADDR_W+2)'(e) + (ADDR_W+2)'(1);
        return (n + (ADDR_W+2)'(l) > lim) ? b : n[ADDR_W-1:0];
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            wr_ch_q   <= '0;
            rd_ch_q   <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_vld_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            sup_q     <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_len_q  <= '0;
            rd_len_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= wr_b[i];
                rd_ptr_q[i] <= rd_b[i];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_addr_rst[i]) begin
                    wr_ptr_q[i] <= wr_b[i];
                    rd_ptr_q[i] <= rd_b[i];
                end
            end
            // A reload that lands on the in-flight channel cancels its end-of-burst advance.
            if (state_q != IDLE && ch_addr_rst[cur_ch])
                sup_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (init_end && pick_any) begin
                        rr_q  <= rr_next;
                        sup_q <= ch_addr_rst[pick_idx];
                        if (grant_wr) begin
                            wr_ch_q   <= pick_idx;
                            wr_addr_q <= wr_ptr_q[pick_idx];
                            wr_len_q  <= wr_burst_len;
                            wr_req_q  <= 1'b1;
                            wr_vld_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            rd_ch_q   <= pick_idx;
                            rd_addr_q <= rd_ptr_q[pick_idx];
                            rd_len_q  <= rd_burst_len;
                            rd_req_q  <= 1'b1;
                            rd_vld_q  <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (sdram_wr_ack) begin
                        wr_req_q <= 1'b0;
                        state_q  <= WR_BURST;
                    end
                end
                WR_BURST: begin
                    if (!sdram_wr_ack) begin
                        wr_vld_q <= 1'b0;
                        state_q  <= IDLE;
                        if (!sup_q && !ch_addr_rst[wr_ch_q])
                            wr_ptr_q[wr_ch_q] <= next_ptr(wr_addr_q, wr_len_q, wr_b[wr_ch_q], wr_e[wr_ch_q]);
                    end
                end
                RD_REQ: begin
                    if (sdram_rd_ack) begin
                        rd_req_q <= 1'b0;
                        state_q  <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (!sdram_rd_ack) begin
                        rd_vld_q <= 1'b0;
                        state_q  <= IDLE;
                        if (!sup_q && !ch_addr_rst[rd_ch_q])
                            rd_ptr_q[rd_ch_q] <= next_ptr(rd_addr_q, rd_len_q, rd_b[rd_ch_q], rd_e[rd_ch_q]);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sdram_wr_req       = wr_req_q;
    assign sdram_wr_addr      = wr_addr_q;
    assign sdram_wr_burst_len = wr_len_q;
    assign sdram_rd_req       = rd_req_q;
    assign sdram_rd_addr      = rd_addr_q;
    assign sdram_rd_burst_len = rd_len_q;
    assign wr_grant_ch        = wr_ch_q;
    assign rd_grant_ch        = rd_ch_q;
    assign wr_grant_vld       = wr_vld_q;
    assign rd_grant_vld       = rd_vld_q;

endmodule
